// File: rtl/pixel_descrambler.sv
// Descrambles an RGB444 pixel stream by XOR with a 12-bit LFSR keystream reloaded at each sof.
// Define PIXEL_DESCRAMBLER_BYPASS_EN to add a bypass input that passes pixels through unmodified.
module pixel_descrambler #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [11:0] SEED     = 12'hCCC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sof,
  input  logic [11:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [11:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        frame_err
`ifdef PIXEL_DESCRAMBLER_BYPASS_EN
  ,
  input  logic        bypass
`endif
);

  localparam int unsigned NPix = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CntW = $clog2(NPix + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [11:0]       key_q, key_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [11:0]       m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              err_q, err_d;

  logic [11:0]       key_src, key_adv, pix;
  logic [CntW-1:0]   idx;
  logic              is_last, out_free, accept, take;

  always_comb begin
    // A pixel arriving with sof is pixel 0 of the new frame, so it uses SEED directly.
    key_src  = sof ? SEED : key_q;
    key_adv  = {key_src[11] ^ key_src[5] ^ key_src[3] ^ key_src[0], key_src[11:1]};
    idx      = sof ? '0 : cnt_q;
    is_last  = (idx == CntW'(NPix - 1));
    out_free = !m_valid_q || m_ready;
    // Pixels dropped in idle need no space; a pixel starting a frame does.
    s_ready  = reset_n && (((state_q == StIdle) && !sof) || out_free);
    accept   = s_valid && s_ready;
    take     = accept && (sof || (state_q == StRun));
`ifdef PIXEL_DESCRAMBLER_BYPASS_EN
    pix      = bypass ? s_data : (s_data ^ key_src);
`else
    pix      = s_data ^ key_src;
`endif

    state_d   = state_q;
    key_d     = key_q;
    cnt_d     = cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    err_d     = err_q;

    if (m_ready) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end

    if (sof) begin
      state_d = StRun;
      key_d   = SEED;
      cnt_d   = '0;
      err_d   = 1'b0;
    end

    if (take) begin
      m_data_d  = pix;
      m_valid_d = 1'b1;
      m_last_d  = is_last;
      key_d     = key_adv;
      if (is_last) begin
        cnt_d   = '0;
        state_d = StIdle;
      end else begin
        cnt_d   = idx + 1'b1;
      end
    end else if (accept) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      key_q     <= SEED;
      cnt_q     <= '0;
      m_data_q  <= 12'h000;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_pixel_descrambler.sv
// Randomized scoreboard bench for pixel_descrambler with a keystream-table reference model.
module tb_pixel_descrambler;

  localparam int HA = 4;
  localparam int VA = 2;
  localparam int NP = HA * VA;
  localparam logic [11:0] SEED = 12'hCCC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sof = 1'b0;
  logic [11:0] s_data = 12'h000;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [11:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic        m_last;
  logic        frame_err;
`ifdef PIXEL_DESCRAMBLER_BYPASS_EN
  logic        bypass = 1'b0;
`endif

  pixel_descrambler #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .sof(sof), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last), .frame_err(frame_err)
`ifdef PIXEL_DESCRAMBLER_BYPASS_EN
    , .bypass(bypass)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // Keystream table: key value used for pixel i of a frame.
  logic [11:0] ks [NP];
  initial begin
    logic [11:0] k;
    k = SEED;
    for (int i = 0; i < NP; i++) begin
      ks[i] = k;
      k = {k[11] ^ k[5] ^ k[3] ^ k[0], k[11:1]};
    end
  end

  typedef struct packed {logic [11:0] d; logic l;} exp_t;
  exp_t q[$];

  bit mod_run = 0;
  int mod_idx = 0;
  bit mod_err = 0;

  // Reference model: evaluates this cycle's inputs, pushes expected outputs.
  always @(negedge clk) begin
    if (!reset_n) begin
      mod_run = 0;
      mod_idx = 0;
      mod_err = 0;
      q.delete();
      chk("s_ready_in_reset", s_ready, 0);
    end else begin
      bit exp_rdy;
      chk("frame_err", frame_err, mod_err);
      exp_rdy = (!mod_run && !sof) ? 1'b1 : (!m_valid || m_ready);
      chk("s_ready", s_ready, exp_rdy);
      if (sof) begin
        mod_run = 1;
        mod_idx = 0;
        mod_err = 0;
      end
      if (s_valid && s_ready) begin
        if (mod_run) begin
          exp_t e;
          e.d = s_data ^ ks[mod_idx];
`ifdef PIXEL_DESCRAMBLER_BYPASS_EN
          if (bypass) e.d = s_data;
`endif
          e.l = (mod_idx == NP - 1);
          q.push_back(e);
          mod_idx++;
          if (e.l) begin
            mod_run = 0;
            mod_idx = 0;
          end
        end else begin
          mod_err = 1;
        end
      end
    end
  end

  bit          prev_stall = 0;
  logic [11:0] prev_data = 12'h000;
  logic        prev_last = 1'b0;

  // Monitor: compares each transferred output against the scoreboard.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_data_stable", m_data, prev_data);
        chk("stall_last_stable", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual %h required none", m_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("m_data", m_data, e.d);
          chk("m_last", m_last, e.l);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    step();
    step();
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_m_data", m_data, 12'h000);
    step();
    reset_n = 1'b1;

    // Three zero pixels expose the keystream
    sof = 1; s_valid = 1; s_data = 12'h000; m_ready = 1;
    step();
    sof = 0;
    @(negedge clk); chk("ks0", m_data, 12'hCCC);
    step();
    @(negedge clk); chk("ks1", m_data, 12'h666);
    step();
    s_valid = 0;
    @(negedge clk); chk("ks2", m_data, 12'hB33);
    step();

    // Backpressure holds data and key
    sof = 1; s_valid = 1; s_data = 12'h000; m_ready = 0;
    step();
    sof = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_s_ready", s_ready, 0);
      chk("bp_hold", m_data, 12'hCCC);
      step();
    end
    m_ready = 1;
    step();
    s_valid = 0;
    @(negedge clk); chk("bp_next", m_data, 12'h666);
    step();

    // Full frame, then an overrun pixel
    sof = 1; s_valid = 1; m_ready = 1;
    for (int i = 0; i < NP; i++) begin
      s_data = 12'($urandom);
      step();
      sof = 0;
    end
    s_valid = 0;
    step();
    s_valid = 1; s_data = 12'h123;
    step();
    s_valid = 0;
    @(negedge clk);
    chk("overrun_err", frame_err, 1);
    chk("overrun_dropped", m_valid, 0);
    sof = 1;
    step();
    sof = 0;
    @(negedge clk); chk("sof_clears_err", frame_err, 0);

    // Mid-frame sof restarts keystream
    sof = 1; s_valid = 1; s_data = 12'h000;
    step();
    sof = 0;
    for (int i = 0; i < 3; i++) step();
    sof = 1;
    step();
    sof = 0; s_valid = 0;
    @(negedge clk); chk("restart_ks", m_data, 12'hCCC);
    step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      sof     = ($urandom_range(0, 59) == 0);
      s_valid = ($urandom_range(0, 9) < 7);
      m_ready = ($urandom_range(0, 9) < 7);
      s_data  = 12'($urandom);
`ifdef PIXEL_DESCRAMBLER_BYPASS_EN
      bypass  = $urandom_range(0, 1) == 1;
`endif
      if (n == 1500) reset_n = 0;
      if (n == 1503) reset_n = 1;
      step();
    end

    // Drain
    sof = 0; s_valid = 0; m_ready = 1;
    for (int i = 0; i < 5; i++) step();
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
